updown_count_decoder: RTL and testbench

//  Receive-side decoder for the sync up/down counter's count bus. Samples the

---
 rtl/updown_pkg.sv | 19 +
 rtl/step_classifier.sv | 31 +++
 rtl/updown_count_decoder.sv | 137 +++++++++++++
 tb/tb_updown_count_decoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/updown_pkg.sv
// Shared types for the up/down count-bus decoder: FSM states and step classes.
package updown_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ACQ       = 3'd1,
        S_LOCK_UP   = 3'd2,
        S_LOCK_DOWN = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        STEP_UP   = 2'd0,
        STEP_DOWN = 2'd1,
        STEP_HOLD = 2'd2,
        STEP_JUMP = 2'd3
    } step_t;

endpackage

// File: rtl/step_classifier.sv
// Combinational classifier: modular difference between two count samples
// mapped to UP/DOWN/HOLD/JUMP, plus detection of a max<->0 crossing.
module step_classifier
    import updown_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] count_in,
    output step_t            step,
    output logic             wrap_hit
);

    logic [WIDTH-1:0] delta;

    always_comb begin
        delta    = count_in - prev;
        step     = STEP_JUMP;
        wrap_hit = 1'b0;
        if (delta == WIDTH'(1)) begin
            step     = STEP_UP;
            wrap_hit = (count_in == '0);
        end else if (delta == '1) begin
            step     = STEP_DOWN;
            wrap_hit = (count_in == '1);
        end else if (delta == '0) begin
            step = STEP_HOLD;
        end
    end

endmodule

// File: rtl/updown_count_decoder.sv
// Monitor-path decoder for an up/down counter bus: recovers direction, run
// length and wrap events, and escalates repeated illegal jumps to FAULT.
module updown_count_decoder
    import updown_pkg::*;
#(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned STEP_W    = 8,
    parameter int unsigned ERR_LIMIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [WIDTH-1:0]  count_in,
    output logic              dir,
    output logic              locked,
    output logic              wrap,
    output logic              step_err,
    output logic [STEP_W-1:0] steps,
    output logic              fault
);

    localparam int unsigned ERR_W = $clog2(ERR_LIMIT + 1);
    localparam logic [STEP_W-1:0] STEPS_MAX = '1;

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  prev_q;
    logic [ERR_W-1:0]  errcnt_q;
    logic [ERR_W-1:0]  errcnt_d;
    logic [ERR_W-1:0]  err_inc;
    logic              dir_d;
    logic              wrap_d;
    logic              step_err_d;
    logic [STEP_W-1:0] steps_d;
    step_t             step;
    logic              wrap_hit;

    step_classifier #(.WIDTH(WIDTH)) u_classifier (
        .prev     (prev_q),
        .count_in (count_in),
        .step     (step),
        .wrap_hit (wrap_hit)
    );

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        state_d    = state_q;
        errcnt_d   = errcnt_q;
        dir_d      = dir;
        steps_d    = steps;
        wrap_d     = 1'b0;
        step_err_d = 1'b0;
        err_inc    = errcnt_q + ERR_W'(1);

        if (sample_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_ACQ;
                end
                S_FAULT: begin
                    if (step == STEP_JUMP) begin
                        step_err_d = 1'b1;
                    end else begin
                        state_d  = S_ACQ;
                        errcnt_d = '0;
                    end
                end
                S_ACQ, S_LOCK_UP, S_LOCK_DOWN: begin
                    wrap_d = wrap_hit;
                    unique case (step)
                        STEP_UP: begin
                            errcnt_d = '0;
                            if (state_q == S_LOCK_UP) begin
                                steps_d = (steps == STEPS_MAX) ? steps : steps + STEP_W'(1);
                            end else begin
                                state_d = S_LOCK_UP;
                                dir_d   = 1'b1;
                                steps_d = STEP_W'(1);
                            end
                        end
                        STEP_DOWN: begin
                            errcnt_d = '0;
                            if (state_q == S_LOCK_DOWN) begin
                                steps_d = (steps == STEPS_MAX) ? steps : steps + STEP_W'(1);
                            end else begin
                                state_d = S_LOCK_DOWN;
                                dir_d   = 1'b0;
                                steps_d = STEP_W'(1);
                            end
                        end
                        STEP_HOLD: begin
                            errcnt_d = '0;
                        end
                        default: begin
                            step_err_d = 1'b1;
                            errcnt_d   = err_inc;
                            if (32'(err_inc) >= ERR_LIMIT) begin
                                state_d = S_FAULT;
                                steps_d = '0;
                            end
                        end
                    endcase
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            prev_q   <= '0;
            errcnt_q <= '0;
            dir      <= 1'b0;
            locked   <= 1'b0;
            wrap     <= 1'b0;
            step_err <= 1'b0;
            steps    <= '0;
            fault    <= 1'b0;
        end else begin
            state_q  <= state_d;
            errcnt_q <= errcnt_d;
            dir      <= dir_d;
            wrap     <= wrap_d;
            step_err <= step_err_d;
            steps    <= steps_d;
            locked   <= (state_d == S_LOCK_UP) || (state_d == S_LOCK_DOWN);
            fault    <= (state_d == S_FAULT);
            if (sample_valid) begin
                prev_q <= count_in;
            end
        end
    end

endmodule

// File: tb/tb_updown_count_decoder.sv
// Self-checking bench for updown_count_decoder: directed scenarios plus a
// randomized run against a behavioural model of the decoding rules.
module tb_updown_count_decoder;

    localparam int MASK  = 7;
    localparam int LIMIT = 2;
    localparam int SMAX  = 255;
    localparam int M_IDLE = 0, M_ACQ = 1, M_UP = 2, M_DN = 3, M_FAULT = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sample_valid = 1'b0;
    logic [2:0] count_in = 3'd0;
    logic       dir, locked, wrap, step_err, fault;
    logic [7:0] steps;

    int total = 0;
    int bad = 0;

    int m_mode, m_prev, m_dir, m_steps, m_err, m_wrap, m_serr;

    updown_count_decoder #(.WIDTH(3), .STEP_W(8), .ERR_LIMIT(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .count_in     (count_in),
        .dir          (dir),
        .locked       (locked),
        .wrap         (wrap),
        .step_err     (step_err),
        .steps        (steps),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = M_IDLE; m_prev = 0; m_dir = 0; m_steps = 0;
        m_err = 0; m_wrap = 0; m_serr = 0;
    endtask

    // Behavioural model: one sample applied with plain integer arithmetic.
    task automatic model_step(input int v, input int c);
        int d;
        m_wrap = 0;
        m_serr = 0;
        if (v != 0) begin
            d = (c - m_prev) & MASK;
            if (m_mode == M_IDLE) begin
                m_mode = M_ACQ;
            end else if (m_mode == M_FAULT) begin
                if (d == 0 || d == 1 || d == MASK) begin
                    m_mode = M_ACQ;
                    m_err = 0;
                end else begin
                    m_serr = 1;
                end
            end else begin
                if ((d == 1 && c == 0) || (d == MASK && c == MASK)) m_wrap = 1;
                if (d == 1) begin
                    m_err = 0;
                    if (m_mode == M_UP) m_steps = (m_steps < SMAX) ? m_steps + 1 : SMAX;
                    else begin m_mode = M_UP; m_dir = 1; m_steps = 1; end
                end else if (d == MASK) begin
                    m_err = 0;
                    if (m_mode == M_DN) m_steps = (m_steps < SMAX) ? m_steps + 1 : SMAX;
                    else begin m_mode = M_DN; m_dir = 0; m_steps = 1; end
                end else if (d == 0) begin
                    m_err = 0;
                end else begin
                    m_serr = 1;
                    m_err++;
                    if (m_err >= LIMIT) begin m_mode = M_FAULT; m_steps = 0; end
                end
            end
            m_prev = c;
        end
    endtask

    // Drive one cycle, then sample outputs 1 time unit after the edge.
    task automatic cyc(input int v, input int c);
        sample_valid = v[0];
        count_in = 3'(c);
        @(posedge clk);
        #1;
        model_step(v, c);
    endtask

    task automatic apply_reset();
        sample_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        repeat (3) cyc(0, 5);
        total++; if ({dir, locked, wrap, step_err, fault} !== 5'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 00000", {dir, locked, wrap, step_err, fault});
        end
        total++; if (steps !== 8'd0) begin
            bad++; $display("FAIL reset_steps: got %0d want 0", steps);
        end
    endtask

    task automatic test_up_wrap();
        int wraps = 0;
        apply_reset();
        cyc(1, 0);
        total++; if (locked !== 1'b0) begin
            bad++; $display("FAIL up_first_sample_locked: got %b want 0", locked);
        end
        cyc(1, 1);
        total++; if (locked !== 1'b1 || dir !== 1'b1 || steps !== 8'd1) begin
            bad++; $display("FAIL up_lock: got locked=%b dir=%b steps=%0d want 1 1 1", locked, dir, steps);
        end
        for (int i = 2; i <= 7; i++) begin
            cyc(1, i);
            if (wrap === 1'b1) wraps++;
        end
        cyc(1, 0);
        total++; if (wrap !== 1'b1 || steps !== 8'd8) begin
            bad++; $display("FAIL up_wrap: got wrap=%b steps=%0d want 1 8", wrap, steps);
        end
        cyc(1, 1);
        total++; if (wrap !== 1'b0 || steps !== 8'd9 || wraps != 0) begin
            bad++; $display("FAIL up_end: got wrap=%b steps=%0d early_wraps=%0d want 0 9 0", wrap, steps, wraps);
        end
    endtask

    task automatic test_down_flip();
        apply_reset();
        cyc(1, 2);
        cyc(1, 3);
        cyc(1, 2);
        total++; if (dir !== 1'b0 || steps !== 8'd1 || locked !== 1'b1) begin
            bad++; $display("FAIL down_flip: got dir=%b steps=%0d locked=%b want 0 1 1", dir, steps, locked);
        end
        cyc(1, 1);
        cyc(1, 0);
        cyc(1, 7);
        total++; if (wrap !== 1'b1 || steps !== 8'd4 || dir !== 1'b0) begin
            bad++; $display("FAIL down_wrap: got wrap=%b steps=%0d dir=%b want 1 4 0", wrap, steps, dir);
        end
    endtask

    task automatic test_jump_fault();
        apply_reset();
        cyc(1, 1);
        cyc(1, 2);
        cyc(1, 5);
        total++; if (step_err !== 1'b1 || locked !== 1'b1 || steps !== 8'd1) begin
            bad++; $display("FAIL jump_first: got err=%b locked=%b steps=%0d want 1 1 1", step_err, locked, steps);
        end
        cyc(1, 1);
        total++; if (fault !== 1'b1 || locked !== 1'b0 || step_err !== 1'b1 || steps !== 8'd0) begin
            bad++; $display("FAIL jump_fault: got fault=%b locked=%b err=%b steps=%0d want 1 0 1 0", fault, locked, step_err, steps);
        end
        cyc(1, 1);
        total++; if (fault !== 1'b0 || locked !== 1'b0 || step_err !== 1'b0) begin
            bad++; $display("FAIL fault_exit: got fault=%b locked=%b err=%b want 0 0 0", fault, locked, step_err);
        end
        cyc(1, 2);
        total++; if (locked !== 1'b1 || steps !== 8'd1 || dir !== 1'b1) begin
            bad++; $display("FAIL relock: got locked=%b steps=%0d dir=%b want 1 1 1", locked, steps, dir);
        end
    endtask

    task automatic test_valid_toggle();
        int wraps = 0;
        int seq[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
        logic [7:0] held;
        apply_reset();
        foreach (seq[i]) begin
            cyc(1, seq[i]);
            if (wrap === 1'b1) wraps++;
            held = steps;
            cyc(0, int'($urandom_range(0, 7)));
            total++; if (wrap !== 1'b0 || step_err !== 1'b0 || steps !== held) begin
                bad++; $display("FAIL toggle_idle[%0d]: got wrap=%b err=%b steps=%0d want 0 0 %0d", i, wrap, step_err, steps, held);
            end
        end
        total++; if (steps !== 8'd9 || locked !== 1'b1 || dir !== 1'b1 || wraps != 1) begin
            bad++; $display("FAIL toggle_end: got steps=%0d locked=%b dir=%b wraps=%0d want 9 1 1 1", steps, locked, dir, wraps);
        end
    endtask

    task automatic test_reset_mid();
        int seq[6] = '{7, 6, 5, 4, 3, 2};
        apply_reset();
        foreach (seq[i]) cyc(1, seq[i]);
        total++; if (locked !== 1'b1 || dir !== 1'b0 || steps !== 8'd5) begin
            bad++; $display("FAIL mid_pre: got locked=%b dir=%b steps=%0d want 1 0 5", locked, dir, steps);
        end
        #2;
        reset = 1'b1;
        #1;
        total++; if ({dir, locked, wrap, step_err, fault} !== 5'b0 || steps !== 8'd0) begin
            bad++; $display("FAIL mid_async: got flags=%b steps=%0d want 00000 0", {dir, locked, wrap, step_err, fault}, steps);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        cyc(1, 4);
        total++; if (locked !== 1'b0) begin
            bad++; $display("FAIL mid_first: got locked=%b want 0", locked);
        end
        cyc(1, 5);
        total++; if (locked !== 1'b1 || dir !== 1'b1 || steps !== 8'd1) begin
            bad++; $display("FAIL mid_relock: got locked=%b dir=%b steps=%0d want 1 1 1", locked, dir, steps);
        end
    endtask

    task automatic test_random();
        int r, c, v, exp_locked, exp_fault;
        apply_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) apply_reset();
            v = ($urandom_range(0, 9) < 8) ? 1 : 0;
            r = int'($urandom_range(0, 99));
            if (r < 50) c = (m_prev + 1) & MASK;
            else if (r < 70) c = (m_prev - 1) & MASK;
            else if (r < 82) c = m_prev;
            else c = int'($urandom_range(0, 7));
            cyc(v, c);
            exp_locked = (m_mode == M_UP || m_mode == M_DN) ? 1 : 0;
            exp_fault = (m_mode == M_FAULT) ? 1 : 0;
            total++;
            if (int'(dir) != m_dir || int'(locked) != exp_locked || int'(wrap) != m_wrap ||
                int'(step_err) != m_serr || int'(steps) != m_steps || int'(fault) != exp_fault) begin
                bad++;
                $display("FAIL random[%0d]: got dir=%b locked=%b wrap=%b err=%b steps=%0d fault=%b want %0d %0d %0d %0d %0d %0d",
                         n, dir, locked, wrap, step_err, steps, fault,
                         m_dir, exp_locked, m_wrap, m_serr, m_steps, exp_fault);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_up_wrap();
        test_down_flip();
        test_jump_fault();
        test_valid_toggle();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
